// File: rtl/spu_issue_scoreboard_pkg.sv
// spu_sched_pkg: shared scheduling definitions for the SPU issue scoreboard.
// Holds the register file geometry, the execution unit ids and the
// unit-id to result-latency mapping used when a writer is granted.
package spu_sched_pkg;

    localparam int NREG  = 128;
    localparam int CNT_W = 3;
    localparam int AW    = $clog2(NREG);

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [2:0]       uid_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam uid_t UID_FX2   = 3'd0;
    localparam uid_t UID_SHIFT = 3'd1;
    localparam uid_t UID_FX3   = 3'd2;
    localparam uid_t UID_BYTE  = 3'd3;
    localparam uid_t UID_FP    = 3'd4;
    localparam uid_t UID_LS    = 3'd5;
    localparam uid_t UID_PERM  = 3'd6;
    localparam uid_t UID_BR    = 3'd7;

    // Cycles from issue until the result can be consumed by a dependent.
    function automatic cnt_t lat_of(input uid_t uid);
        cnt_t lat;
        case (uid)
            UID_FX2, UID_BR: lat = cnt_t'(2);
            UID_FP,  UID_LS: lat = cnt_t'(6);
            default:         lat = cnt_t'(4);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/spu_issue_scoreboard_if.sv
// spu_issue_scoreboard_if: decode-to-scoreboard issue bundle.
// Carries both issue slots (even _e, odd _o) with their destination and
// source operands, the flush strobe, and the grant/stall results.
//   master : decode side, drives requests, receives grants
//   slave  : scoreboard side, receives requests, drives grants
interface spu_issue_scoreboard_if #(
    parameter int PERF_W = 16
) ();
    import spu_sched_pkg::*;

    logic      req_e;
    uid_t      uid_e;
    logic      wreg_e;
    reg_addr_t rtaddr_e;
    reg_addr_t ra_addr_e, rb_addr_e, rc_addr_e;
    logic      ra_use_e, rb_use_e, rc_use_e;

    logic      req_o;
    uid_t      uid_o;
    logic      wreg_o;
    reg_addr_t rtaddr_o;
    reg_addr_t ra_addr_o, rb_addr_o, rc_addr_o;
    logic      ra_use_o, rb_use_o, rc_use_o;

    logic      flush;

    logic              grant_e;
    logic              grant_o;
    logic              stall;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output req_e, uid_e, wreg_e, rtaddr_e,
               ra_addr_e, rb_addr_e, rc_addr_e, ra_use_e, rb_use_e, rc_use_e,
               req_o, uid_o, wreg_o, rtaddr_o,
               ra_addr_o, rb_addr_o, rc_addr_o, ra_use_o, rb_use_o, rc_use_o,
               flush,
        input  grant_e, grant_o, stall, stall_cnt
    );

    modport slave (
        input  req_e, uid_e, wreg_e, rtaddr_e,
               ra_addr_e, rb_addr_e, rc_addr_e, ra_use_e, rb_use_e, rc_use_e,
               req_o, uid_o, wreg_o, rtaddr_o,
               ra_addr_o, rb_addr_o, rc_addr_o, ra_use_o, rb_use_o, rc_use_o,
               flush,
        output grant_e, grant_o, stall, stall_cnt
    );

endinterface

// File: rtl/spu_issue_scoreboard_hazard.sv
// spu_sb_hazard: combinational readiness check for one issue slot.
// rdy_o is high when every used source and (if written) the destination
// have a zero countdown, and none of them collides with an older
// same-cycle writer flagged by blk_vld_i/blk_addr_i.
// Ports:
//   cnt_i             countdown array of all registers
//   ra/rb/rc_addr_i   source register addresses, ra/rb/rc_use_i valid
//   wreg_i, rt_i      slot writes rt_i
//   blk_vld_i         an older slot is writing blk_addr_i this cycle
//   rdy_o             slot is free of hazards
module spu_sb_hazard
    import spu_sched_pkg::*;
#(
    parameter int NREG  = spu_sched_pkg::NREG,
    parameter int CNT_W = spu_sched_pkg::CNT_W
) (
    input  logic [NREG-1:0][CNT_W-1:0] cnt_i,
    input  reg_addr_t                  ra_addr_i,
    input  reg_addr_t                  rb_addr_i,
    input  reg_addr_t                  rc_addr_i,
    input  logic                       ra_use_i,
    input  logic                       rb_use_i,
    input  logic                       rc_use_i,
    input  logic                       wreg_i,
    input  reg_addr_t                  rt_i,
    input  logic                       blk_vld_i,
    input  reg_addr_t                  blk_addr_i,
    output logic                       rdy_o
);

    logic ra_ok, rb_ok, rc_ok, rt_ok;

    // A same-cycle collision with the older slot covers both RAW (sources)
    // and WAW (destination).
    assign ra_ok = ~ra_use_i | ((cnt_i[ra_addr_i] == '0) & ~(blk_vld_i & (ra_addr_i == blk_addr_i)));
    assign rb_ok = ~rb_use_i | ((cnt_i[rb_addr_i] == '0) & ~(blk_vld_i & (rb_addr_i == blk_addr_i)));
    assign rc_ok = ~rc_use_i | ((cnt_i[rc_addr_i] == '0) & ~(blk_vld_i & (rc_addr_i == blk_addr_i)));
    assign rt_ok = ~wreg_i   | ((cnt_i[rt_i]      == '0) & ~(blk_vld_i & (rt_i      == blk_addr_i)));

    assign rdy_o = ra_ok & rb_ok & rc_ok & rt_ok;

endmodule

// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard: dual-issue scoreboard and in-order issue arbiter
// for the SPU even/odd pipes. A per-register countdown tracks how far each
// in-flight result has travelled; a register is ready when its count is 0.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       issue bundle (slave side): requests in, grants/stall out.
//             grant_e/grant_o/stall are combinational, stall_cnt registered.
module spu_issue_scoreboard #(
    parameter int NREG   = spu_sched_pkg::NREG,
    parameter int CNT_W  = spu_sched_pkg::CNT_W,
    parameter int PERF_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    spu_issue_scoreboard_if.slave  bus
);
    import spu_sched_pkg::*;

    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PERF_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic                       rdy_e, rdy_o;
    logic                       grant_e, grant_o, stall;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

    spu_sb_hazard #(.NREG(NREG), .CNT_W(CNT_W)) u_haz_e (
        .cnt_i      (cnt_q),
        .ra_addr_i  (bus.ra_addr_e),
        .rb_addr_i  (bus.rb_addr_e),
        .rc_addr_i  (bus.rc_addr_e),
        .ra_use_i   (bus.ra_use_e),
        .rb_use_i   (bus.rb_use_e),
        .rc_use_i   (bus.rc_use_e),
        .wreg_i     (bus.wreg_e),
        .rt_i       (bus.rtaddr_e),
        .blk_vld_i  (1'b0),
        .blk_addr_i ('0),
        .rdy_o      (rdy_e)
    );

    // The odd slot is younger: it must not read or overwrite the register
    // the even slot is writing in the same cycle.
    spu_sb_hazard #(.NREG(NREG), .CNT_W(CNT_W)) u_haz_o (
        .cnt_i      (cnt_q),
        .ra_addr_i  (bus.ra_addr_o),
        .rb_addr_i  (bus.rb_addr_o),
        .rc_addr_i  (bus.rc_addr_o),
        .ra_use_i   (bus.ra_use_o),
        .rb_use_i   (bus.rb_use_o),
        .rc_use_i   (bus.rc_use_o),
        .wreg_i     (bus.wreg_o),
        .rt_i       (bus.rtaddr_o),
        .blk_vld_i  (grant_e & bus.wreg_e),
        .blk_addr_i (bus.rtaddr_e),
        .rdy_o      (rdy_o)
    );

    assign grant_e = bus.req_e & ~bus.flush & rdy_e;
    // In-order issue: odd may only go if even goes or is absent.
    assign grant_o = bus.req_o & ~bus.flush & (grant_e | ~bus.req_e) & rdy_o;
    assign stall   = (bus.req_e & ~grant_e) | (bus.req_o & ~grant_o);

    // Counters keep draining under flush; results already in flight still
    // write back. A fresh load overrides the decrement on its entry, and WAW
    // blocking guarantees the two loads never target the same entry.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
        end
        if (grant_e & bus.wreg_e) begin
            cnt_d[bus.rtaddr_e] = CNT_W'(lat_of(bus.uid_e)) - CNT_W'(1);
        end
        if (grant_o & bus.wreg_o) begin
            cnt_d[bus.rtaddr_o] = CNT_W'(lat_of(bus.uid_o)) - CNT_W'(1);
        end
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.grant_e   = grant_e;
    assign bus.grant_o   = grant_o;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/spu_issue_scoreboard.md
# spu_issue_scoreboard

Dual-issue scoreboard and issue arbiter for the SPU even/odd execution pipes. Tracks in-flight register writes per 128-entry register file and grants or stalls each issue slot in the cycle it is presented. Sits between decode and the FF1..FF7 pipeline stage chain. The per-register countdown mirrors how far each result has travelled through the stages, so dependent instructions issue exactly when the producing result becomes available.

## Interface
Parameters:
- NREG, 128, register file depth (address width 7)
- CNT_W, 3, countdown width per register (max latency 7)
- PERF_W, 16, stall performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_e / req_o  in  1  issue request, even / odd slot
- uid_e / uid_o  in  3  execution unit id; selects latency
- wreg_e / wreg_o  in  1  instruction writes rt
- rtaddr_e / rtaddr_o  in  7  destination register
- ra/rb/rc_addr_e, ra/rb/rc_addr_o  in  7 each  source registers
- ra/rb/rc_use_e, ra/rb/rc_use_o  in  1 each  source valid
- flush  in  1  kill both requests this cycle
- grant_e / grant_o  out  1  slot issues this cycle (combinational)
- stall  out  1  req_e & ~grant_e, or req_o & ~grant_o
- stall_cnt  out  PERF_W  saturating count of stall cycles (registered)

## Operation
- State: cnt[0..127], CNT_W bits each. cnt==0 means the register is ready.
- Latency by uid (package constants): 0 FX2=2, 1 SHIFT=4, 2 FX3=4, 3 BYTE=4, 4 FP=6, 5 LS=6, 6 PERM=4, 7 BR=2.
- Even slot is older than odd slot.
- grant_e = req_e & ~flush & all used sources of e have cnt==0 & (~wreg_e | cnt[rtaddr_e]==0).
- grant_o = req_o & ~flush & (grant_e | ~req_e) & all used sources of o have cnt==0 & (~wreg_o | cnt[rtaddr_o]==0) & no RAW on e (any used source of o == rtaddr_e while grant_e & wreg_e) & no WAW on e (wreg_o & grant_e & wreg_e & rtaddr_o==rtaddr_e).
- Update each cycle: every nonzero cnt decrements by 1. On grant with wreg, cnt[rt] <= LAT(uid)-1. A load wins over a decrement on the same entry.
- Both slots load different entries (WAW is blocked), so there is never a write collision.
- flush affects grants only. In-flight counters keep decrementing, since results already in FF stages still write back.
- stall_cnt increments when stall=1 and saturates at all-ones.

## Timing
- Reset (async assert, sync release): all cnt=0, stall_cnt=0. grant_e, grant_o and stall are 0 while no requests are present.
- Grant is same-cycle (combinational from registered cnt and inputs). Counters update on the next clk edge.
- Producer granted at cycle N with latency L: a consumer is granted no earlier than cycle N+L, because cnt=L-1 at N+1 and reaches 0 at N+L.
- Register not busy: zero-cycle penalty. Odd slot dependent on even in the same cycle: odd stalls, re-presents, and is granted per the rule above.
- Reset mid-operation clears all scoreboard state immediately. Pending results are dropped by the pipeline reset.

## Structure
- Shared package spu_sched_pkg holds the UID_* constants, the LAT table function lat_of(uid), and NREG/CNT_W.
- One natural sub-module: spu_sb_hazard, a combinational per-slot source/dest readiness check instantiated twice.
- The counter array and stall counter live in the top module.

## Test plan
- Reset mid-run with cnt[5]=3: assert rst -> all cnt=0 and stall_cnt=0 asynchronously. req_e reading r5 the next cycle -> grant_e=1.
- Even FP (uid 4) writes r10 at cycle 0, then even reads r10 from cycle 1 -> grant_e=0 on cycles 1-5, grant_e=1 at cycle 6, stall_cnt=5.
- Same cycle: even writes r20 (FX2), odd reads r20 -> grant_e=1, grant_o=0. Odd re-presented -> grant_o=1 at cycle 2.
- WAW same cycle: both slots write r7 -> grant_e=1, grant_o=0. Odd re-presented, with cnt[7]=1 at cycle 1 for FX2 -> grant_o=1 at cycle 2.
- req_e blocked on busy r3 while odd is independent -> grant_o=0 (in-order). flush=1 with ready operands -> both grants 0 and cnt keeps decrementing.
- Hold stall for 70000 cycles with PERF_W=16 -> stall_cnt saturates at 0xFFFF.
